// File: rtl/config_loader.sv
// Streams a header plus (address, data) pairs from a ready/valid source onto the
// shared tile configuration bus, dropping and flagging writes to nonexistent tiles.
module config_loader #(
  parameter int NUM_TILES  = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        config_write,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] pairs_done
);

  typedef enum logic [2:0] {IDLE, HDR, ADDR, DATA, WRITE, GAP, DONE} state_t;

  localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] n_reg;
  logic [31:0] addr_reg;
  logic [3:0]  gap_cnt_reg;
  logic        xfer;
  logic        tile_ok;
  logic        more_pairs;

  assign xfer       = in_valid && in_ready;
  assign tile_ok    = {1'b0, addr_reg[15:0]} < 17'(NUM_TILES);
  // pairs_done already counts the pair just finished once WRITE/GAP are reached
  assign more_pairs = pairs_done < n_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = HDR;
      HDR:   if (xfer) state_next = (in_data[15:0] == 16'd0) ? DONE : ADDR;
      ADDR:  if (xfer) state_next = DATA;
      DATA:  if (xfer) state_next = WRITE;
      WRITE: begin
        if (GAP_CYCLES > 0) state_next = GAP;
        else                state_next = more_pairs ? ADDR : DONE;
      end
      GAP:   if (gap_cnt_reg == 4'd0) state_next = more_pairs ? ADDR : DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are derived from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      n_reg        <= 16'd0;
      addr_reg     <= 32'd0;
      gap_cnt_reg  <= 4'd0;
      in_ready     <= 1'b0;
      config_addr  <= 32'd0;
      config_data  <= 32'd0;
      config_write <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      pairs_done   <= 16'd0;
    end else begin
      state_reg    <= state_next;
      in_ready     <= state_next inside {HDR, ADDR, DATA};
      busy         <= state_next != IDLE;
      done         <= state_next == DONE;
      config_write <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            error      <= 1'b0;
            pairs_done <= 16'd0;
          end
        end
        HDR:  if (xfer) n_reg <= in_data[15:0];
        ADDR: if (xfer) addr_reg <= in_data;
        DATA: begin
          // The strobe and the bus update land together so the WRITE cycle sees them.
          if (xfer) begin
            pairs_done <= pairs_done + 16'd1;
            if (tile_ok) begin
              config_write <= 1'b1;
              config_addr  <= addr_reg;
              config_data  <= in_data;
            end else begin
              error <= 1'b1;
            end
          end
        end
        WRITE: gap_cnt_reg <= GAP_LAST;
        GAP:   if (gap_cnt_reg != 4'd0) gap_cnt_reg <= gap_cnt_reg - 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: drives header/pair streams and checks strobes,
// timing, error flagging, reset behaviour and start-while-busy immunity.
module tb_config_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        config_write;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] pairs_done;

  always #5 clk = ~clk;

  config_loader #(.NUM_TILES(16), .GAP_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .config_addr(config_addr), .config_data(config_data),
    .config_write(config_write), .busy(busy), .done(done), .error(error),
    .pairs_done(pairs_done)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] stream_q[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];
  int          done_cyc;
  int          err_cyc;
  int          viol;
  int          idx;
  bit          start_spam;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lists();
    stream_q.delete(); exp_addr.delete(); exp_data.delete();
  endtask

  task automatic add_pair(input logic [31:0] a, input logic [31:0] d, input bit valid_tile);
    stream_q.push_back(a);
    stream_q.push_back(d);
    if (valid_tile) begin
      exp_addr.push_back(a);
      exp_data.push_back(d);
    end
  endtask

  // Runs one load from IDLE, feeding stream_q with the given in_valid duty cycle.
  task automatic do_load(input int duty);
    int cyc;
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    done_cyc = -1; err_cyc = -1; viol = 0; idx = 0; cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (done_cyc < 0 && cyc < 3000) begin
      start = start_spam;
      if (idx < stream_q.size() && int'($urandom_range(99)) < duty) begin
        in_valid = 1'b1;
        in_data  = stream_q[idx];
        if (in_ready) idx++;
      end else begin
        in_valid = 1'b0;
        in_data  = $urandom;
      end
      step();
      cyc++;
      if (config_write) begin
        got_addr.push_back(config_addr);
        got_data.push_back(config_data);
        got_cyc.push_back(cyc);
        $display("write cyc=%0d addr=%h data=%h", cyc, config_addr, config_data);
      end
      if (in_ready && (config_write || done || !busy)) viol++;
      if (error && err_cyc < 0) err_cyc = cyc;
      if (done) done_cyc = cyc;
    end
    start = 1'b0;
    in_valid = 1'b0;
    chk("done_seen", 64'(done_cyc >= 0), 64'd1);
    chk("stream_consumed", 64'(idx), 64'(stream_q.size()));
    chk("ready_protocol", 64'(viol), 64'd0);
    chk("n_strobes", 64'(got_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      chk($sformatf("strobe%0d_addr", i), 64'(got_addr[i]), 64'(exp_addr[i]));
      chk($sformatf("strobe%0d_data", i), 64'(got_data[i]), 64'(exp_data[i]));
    end
    step();
    chk("idle_after_done", {62'd0, busy, done}, 64'd0);
    if (exp_addr.size() > 0)
      chk("bus_hold", {config_addr, config_data},
          {exp_addr[exp_addr.size()-1], exp_data[exp_data.size()-1]});
  endtask

  task automatic feed_word(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    for (int k = 0; k < 50 && !in_ready; k++) step();
    chk("feed_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 32'd0; start_spam = 1'b0;
    step(); step();
    chk("reset_outputs", {in_ready, config_write, busy, done, error, pairs_done},
        64'd0);
    chk("reset_bus", {config_addr, config_data}, 64'd0);
    reset = 1'b0;
    step();

    // Two valid pairs, in_valid always high: strobes at cycles 3 and 7, done at 9.
    clear_lists();
    stream_q.push_back(32'd2);
    add_pair(32'h0000_0001, 32'hA5A5_A5A5, 1'b1);
    add_pair(32'h0000_0003, 32'h0000_00FF, 1'b1);
    do_load(100);
    chk("t1_strobe0_cyc", 64'(got_cyc.size() > 0 ? got_cyc[0] : -1), 64'd3);
    chk("t1_strobe1_cyc", 64'(got_cyc.size() > 1 ? got_cyc[1] : -1), 64'd7);
    chk("t1_done_cyc", 64'(done_cyc), 64'd9);
    chk("t1_pairs_done", 64'(pairs_done), 64'd2);
    chk("t1_error", 64'(error), 64'd0);

    // Empty load: done one cycle after the header transfer.
    clear_lists();
    stream_q.push_back(32'h0000_0000);
    do_load(100);
    chk("t2_done_cyc", 64'(done_cyc), 64'd1);
    chk("t2_pairs_done", 64'(pairs_done), 64'd0);

    // Tile 16 is out of range: dropped and flagged, following pair still written.
    clear_lists();
    stream_q.push_back(32'd2);
    add_pair(32'h0000_0010, 32'h1111_2222, 1'b0);
    add_pair(32'h0000_0005, 32'h3333_4444, 1'b1);
    do_load(100);
    chk("t3_err_cyc", 64'(err_cyc), 64'd3);
    chk("t3_strobe_cyc", 64'(got_cyc.size() > 0 ? got_cyc[0] : -1), 64'd7);
    chk("t3_error", 64'(error), 64'd1);
    chk("t3_pairs_done", 64'(pairs_done), 64'd2);

    // Sparse in_valid, five pairs incl. tile 15 and upper address bits set.
    clear_lists();
    stream_q.push_back(32'hBEEF_0005);
    add_pair(32'h0000_0000, 32'h0123_4567, 1'b1);
    add_pair(32'h0000_000F, 32'h89AB_CDEF, 1'b1);
    add_pair(32'hDEAD_0007, 32'hFFFF_FFFF, 1'b1);
    add_pair(32'h0000_0008, 32'h0000_0000, 1'b1);
    add_pair(32'h0001_0002, 32'h5A5A_0F0F, 1'b1);
    do_load(30);
    chk("t4_pairs_done", 64'(pairs_done), 64'd5);
    chk("t4_error_cleared", 64'(error), 64'd0);

    // Reset while in DATA of pair 2.
    start = 1'b1;
    step();
    start = 1'b0;
    feed_word(32'd3);
    feed_word(32'h0000_0009);
    feed_word(32'h7777_8888);
    feed_word(32'h0000_000A);
    chk("t5_in_data_state", {62'd0, in_ready, busy}, 64'd3);
    reset = 1'b1; in_valid = 1'b1; in_data = 32'h9999_AAAA;
    step();
    reset = 1'b0; in_valid = 1'b0;
    chk("t5_reset_ctrl", {in_ready, config_write, busy, done, error, pairs_done}, 64'd0);
    chk("t5_reset_bus", {config_addr, config_data}, 64'd0);
    step();
    chk("t5_no_strobe", {62'd0, config_write, busy}, 64'd0);
    clear_lists();
    stream_q.push_back(32'd1);
    add_pair(32'h0000_0004, 32'hCAFE_F00D, 1'b1);
    do_load(100);
    chk("t5_pairs_done", 64'(pairs_done), 64'd1);

    // start held high throughout a load must not restart it or clear error.
    clear_lists();
    stream_q.push_back(32'd2);
    add_pair(32'h0000_0020, 32'h0BAD_0BAD, 1'b0);
    add_pair(32'h0000_0002, 32'h600D_600D, 1'b1);
    start_spam = 1'b1;
    do_load(100);
    start_spam = 1'b0;
    chk("t6_done_cyc", 64'(done_cyc), 64'd9);
    chk("t6_err_cyc", 64'(err_cyc), 64'd3);
    chk("t6_error", 64'(error), 64'd1);
    chk("t6_pairs_done", 64'(pairs_done), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
